// File: rtl/keypad_scanner_if.sv
// Keypad-side and result-side signals of keypad_scanner bundled as one interface.
// master = the scanner, slave = whoever drives the keypad model / consumes key events.
interface keypad_scanner_if;
   logic [3:0]  col_in;
   logic [3:0]  row_out;
   logic [3:0]  key_out;
   logic        key_valid_out;
   logic        key_held_out;
   logic        multi_out;
   logic [31:0] val_out;

   modport master (
      input  col_in,
      output row_out, key_out, key_valid_out, key_held_out, multi_out, val_out
   );

   modport slave (
      output col_in,
      input  row_out, key_out, key_valid_out, key_held_out, multi_out, val_out
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold row strobe, whole-scan debounce, one-cycle key events.
// Define KEYPAD_ACCUM_EN to build the 32-bit hex-digit accumulator driving val_out.
module keypad_scanner #(
   parameter int SCAN_COUNT     = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   keypad_scanner_if.master kp
);

   localparam logic [31:0] LP_SCAN = 32'(SCAN_COUNT);
   localparam logic [3:0]  LP_DB   = 4'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAND,
      ST_PRESSED
   } state_t;

   logic [3:0]  r_col_s1;
   logic [3:0]  r_col_s2;
   logic [3:0]  w_col;

   logic [31:0] r_dwell;
   logic [3:0]  r_row;
   logic [1:0]  r_row_idx;
   logic        r_scan_done;
   logic [1:0]  r_cnt;
   logic [3:0]  r_code;
   logic        w_sample;
   logic [1:0]  w_cnt_next;
   logic [3:0]  w_code_next;

   state_t      r_state;
   logic [3:0]  r_cand;
   logic [3:0]  r_match;
   logic [3:0]  r_rel;
   logic [3:0]  r_key;
   logic        r_valid;
   logic        r_held;
   logic        r_multi;
   logic        w_none;
   logic        w_single;
   logic        w_accept;

   // Two-flop synchronizer; columns are pulled up, so invert to get 1 = closed.
   always_ff @(posedge clk_in) begin
      r_col_s1 <= kp.col_in;
      r_col_s2 <= r_col_s1;
   end

   assign w_col    = ~r_col_s2;
   assign w_sample = (r_dwell == LP_SCAN);

   always_comb begin
      w_cnt_next  = r_cnt;
      w_code_next = r_code;
      for (int c = 0; c < 4; c++) begin
         if (w_col[c]) begin
            if (w_cnt_next != 2'd2) begin
               w_cnt_next = w_cnt_next + 2'd1;
            end
            w_code_next = {r_row_idx, 2'(c)};
         end
      end
   end

   // Row sequencer and per-scan accumulation; scan_done follows the row-3 sample.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_dwell     <= '0;
         r_row       <= 4'b1110;
         r_row_idx   <= 2'd0;
         r_scan_done <= 1'b0;
         r_cnt       <= 2'd0;
         r_code      <= 4'd0;
      end else begin
         r_scan_done <= w_sample && (r_row_idx == 2'd3);
         if (w_sample) begin
            r_dwell   <= '0;
            r_row     <= {r_row[2:0], r_row[3]};
            r_row_idx <= r_row_idx + 2'd1;
            r_cnt     <= w_cnt_next;
            r_code    <= w_code_next;
         end else begin
            r_dwell <= r_dwell + 32'd1;
            if (r_scan_done) begin
               r_cnt  <= 2'd0;
               r_code <= 4'd0;
            end
         end
      end
   end

   assign w_none   = (r_cnt == 2'd0);
   assign w_single = (r_cnt == 2'd1);
   assign w_accept = r_scan_done && (r_state == ST_CAND) && w_single &&
                     (r_code == r_cand) && ((r_match + 4'd1) == LP_DB);

   // Debounce FSM; only a return to IDLE re-arms the next key event.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= ST_IDLE;
         r_cand  <= 4'd0;
         r_match <= 4'd0;
         r_rel   <= 4'd0;
         r_key   <= 4'd0;
         r_valid <= 1'b0;
         r_held  <= 1'b0;
         r_multi <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (r_scan_done) begin
            r_multi <= (r_cnt == 2'd2);
            case (r_state)
               ST_IDLE: begin
                  if (w_single) begin
                     r_cand  <= r_code;
                     r_match <= 4'd1;
                     r_state <= ST_CAND;
                  end
               end
               ST_CAND: begin
                  if (w_accept) begin
                     r_match <= LP_DB;
                     r_key   <= r_cand;
                     r_valid <= 1'b1;
                     r_held  <= 1'b1;
                     r_rel   <= 4'd0;
                     r_state <= ST_PRESSED;
                  end else if (w_single && (r_code == r_cand)) begin
                     r_match <= r_match + 4'd1;
                  end else if (w_single) begin
                     r_cand  <= r_code;
                     r_match <= 4'd1;
                  end else begin
                     r_match <= 4'd0;
                     r_state <= ST_IDLE;
                  end
               end
               ST_PRESSED: begin
                  if (w_none) begin
                     if ((r_rel + 4'd1) == LP_DB) begin
                        r_rel   <= 4'd0;
                        r_match <= 4'd0;
                        r_held  <= 1'b0;
                        r_state <= ST_IDLE;
                     end else begin
                        r_rel <= r_rel + 4'd1;
                     end
                  end else begin
                     r_rel <= 4'd0;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

`ifdef KEYPAD_ACCUM_EN
   logic [31:0] r_val;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_val <= 32'h0;
      end else if (w_accept) begin
         r_val <= {r_val[27:0], r_cand};
      end
   end

   assign kp.val_out = r_val;
`else
   assign kp.val_out = 32'h0;
`endif

   assign kp.row_out       = r_row;
   assign kp.key_out       = r_key;
   assign kp.key_valid_out = r_valid;
   assign kp.key_held_out  = r_held;
   assign kp.multi_out     = r_multi;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_COUNT=7 (32-cycle scans) and DEBOUNCE_SCANS=3.
// A keypad model closes columns from a 16-bit key mask; a scoreboard tracks expected key events.
module tb_keypad_scanner;

   logic        clk;
   logic        rst;
   logic [15:0] keys;
   logic [3:0]  tb_col;
   int          n_cmp;
   int          n_err;
   int          n_pulses;
   logic [31:0] exp_val;
   logic [3:0]  exp_q[$];

   keypad_scanner_if kif ();

   keypad_scanner #(
      .SCAN_COUNT    (7),
      .DEBOUNCE_SCANS(3)
   ) dut (
      .clk_in(clk),
      .rst_in(rst),
      .kp    (kif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Passive matrix: a closed key pulls its column low while its row is driven low.
   always_comb begin
      tb_col = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && (kif.row_out[r] === 1'b0)) begin
               tb_col[c] = 1'b0;
            end
         end
      end
   end

   assign kif.col_in = tb_col;

   task automatic wait_scan_start();
      logic [3:0] prev;
      bit         found;
      found = 1'b0;
      prev  = kif.row_out;
      for (int n = 0; n < 100 && !found; n++) begin
         @(negedge clk);
         if (prev !== 4'b1110 && kif.row_out === 4'b1110) found = 1'b1;
         prev = kif.row_out;
      end
      if (!found) begin
         n_cmp++;
         n_err++;
         $display("FAIL scan_timeout row_out=%b required a return to 1110 within 100 cycles", kif.row_out);
      end
   endtask

   // Steps to the cycle after the next scan_done and retires any key event there.
   task automatic next_scan();
      logic [3:0] code;
      wait_scan_start();
      @(negedge clk);
      if (kif.key_valid_out === 1'b1) begin
         n_pulses++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected key_out=%0d required no event", kif.key_out);
         end else begin
            code = exp_q.pop_front();
            if (kif.key_out !== code) begin
               n_err++;
               $display("FAIL sb_key_out got %0d required %0d", kif.key_out, code);
            end
`ifdef KEYPAD_ACCUM_EN
            exp_val = {exp_val[27:0], code};
`endif
            n_cmp++;
            if (kif.val_out !== exp_val) begin
               n_err++;
               $display("FAIL sb_val_out got %h required %h", kif.val_out, exp_val);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      keys = 16'h0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (kif.row_out !== 4'b1110) begin
         n_err++;
         $display("FAIL reset_row got %b required 1110", kif.row_out);
      end
      n_cmp++;
      if ({kif.key_out, kif.key_valid_out, kif.key_held_out, kif.multi_out} !== 7'd0) begin
         n_err++;
         $display("FAIL reset_outputs got key=%0d vld=%b held=%b multi=%b required all 0",
                  kif.key_out, kif.key_valid_out, kif.key_held_out, kif.multi_out);
      end
      n_cmp++;
      if (kif.val_out !== 32'h0) begin
         n_err++;
         $display("FAIL reset_val got %h required 0", kif.val_out);
      end
      rst     = 1'b0;
      exp_val = 32'h0;
      repeat (7) @(negedge clk);
      n_cmp++;
      if (kif.row_out !== 4'b1110) begin
         n_err++;
         $display("FAIL reset_row_dwell got %b required 1110 after 7 cycles", kif.row_out);
      end
      @(negedge clk);
      n_cmp++;
      if (kif.row_out !== 4'b1101) begin
         n_err++;
         $display("FAIL reset_row_step got %b required 1101 after 8 cycles", kif.row_out);
      end
   endtask

   task automatic test_clean_press();
      int p0;
      p0 = n_pulses;
      wait_scan_start();
      keys = 16'h0040;
      exp_q.push_back(4'd6);
      for (int k = 1; k <= 10; k++) begin
         next_scan();
         n_cmp++;
         if (kif.key_valid_out !== (k == 3)) begin
            n_err++;
            $display("FAIL press_valid scan %0d got %b required %b", k, kif.key_valid_out, (k == 3));
         end
         n_cmp++;
         if (kif.key_held_out !== (k >= 3)) begin
            n_err++;
            $display("FAIL press_held scan %0d got %b required %b", k, kif.key_held_out, (k >= 3));
         end
      end
      n_cmp++;
      if (n_pulses - p0 != 1 || kif.key_out !== 4'd6) begin
         n_err++;
         $display("FAIL press_count got %0d pulses key=%0d required 1 pulse key=6", n_pulses - p0, kif.key_out);
      end
      n_cmp++;
`ifdef KEYPAD_ACCUM_EN
      if (kif.val_out !== 32'h6) begin
         n_err++;
         $display("FAIL press_val got %h required 00000006", kif.val_out);
      end
`else
      if (kif.val_out !== 32'h0) begin
         n_err++;
         $display("FAIL press_val got %h required 00000000", kif.val_out);
      end
`endif
      keys = 16'h0;
      for (int k = 1; k <= 4; k++) begin
         next_scan();
         n_cmp++;
         if (kif.key_held_out !== (k < 3)) begin
            n_err++;
            $display("FAIL release_held scan %0d got %b required %b", k, kif.key_held_out, (k < 3));
         end
      end
   endtask

   task automatic test_bounce();
      for (int rep = 0; rep < 4; rep++) begin
         keys = 16'h0040;
         for (int k = 0; k < 3; k++) begin
            if (k == 2) keys = 16'h0;
            next_scan();
            n_cmp++;
            if (kif.key_valid_out !== 1'b0 || kif.key_held_out !== 1'b0) begin
               n_err++;
               $display("FAIL bounce rep %0d scan %0d got vld=%b held=%b required 0/0",
                        rep, k, kif.key_valid_out, kif.key_held_out);
            end
         end
      end
      n_cmp++;
      if (kif.key_out !== 4'd6) begin
         n_err++;
         $display("FAIL bounce_key_hold got %0d required 6", kif.key_out);
      end
   endtask

   task automatic test_multi();
      keys = 16'h0021;
      for (int k = 1; k <= 6; k++) begin
         next_scan();
         n_cmp++;
         if (kif.multi_out !== 1'b1 || kif.key_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL multi scan %0d got multi=%b vld=%b required 1/0", k, kif.multi_out, kif.key_valid_out);
         end
      end
      keys = 16'h0;
      next_scan();
      n_cmp++;
      if (kif.multi_out !== 1'b0) begin
         n_err++;
         $display("FAIL multi_release got %b required 0", kif.multi_out);
      end
   endtask

   task automatic test_accum();
      int p0;
      p0 = n_pulses;
      for (int d = 1; d <= 9; d++) begin
         keys = 16'(1) << d;
         exp_q.push_back(4'(d));
         for (int k = 1; k <= 4; k++) begin
            next_scan();
            n_cmp++;
            if (kif.key_valid_out !== (k == 3)) begin
               n_err++;
               $display("FAIL accum_valid key %0d scan %0d got %b required %b", d, k, kif.key_valid_out, (k == 3));
            end
         end
         keys = 16'h0;
         repeat (4) next_scan();
      end
      n_cmp++;
      if (n_pulses - p0 != 9) begin
         n_err++;
         $display("FAIL accum_pulses got %0d required 9", n_pulses - p0);
      end
      n_cmp++;
`ifdef KEYPAD_ACCUM_EN
      if (kif.val_out !== 32'h23456789) begin
         n_err++;
         $display("FAIL accum_val got %h required 23456789", kif.val_out);
      end
`else
      if (kif.val_out !== 32'h0) begin
         n_err++;
         $display("FAIL accum_val got %h required 00000000", kif.val_out);
      end
`endif
   endtask

   task automatic test_reset_mid_debounce();
      keys = 16'h0008;
      for (int k = 1; k <= 2; k++) begin
         next_scan();
         n_cmp++;
         if (kif.key_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL mid_pre_valid scan %0d got %b required 0", k, kif.key_valid_out);
         end
      end
      rst = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      exp_val = 32'h0;
      n_cmp++;
      if (kif.row_out !== 4'b1110 || kif.key_out !== 4'd0 || kif.key_held_out !== 1'b0 ||
          kif.key_valid_out !== 1'b0 || kif.multi_out !== 1'b0 || kif.val_out !== 32'h0) begin
         n_err++;
         $display("FAIL mid_reset_state got row=%b key=%0d held=%b vld=%b multi=%b val=%h required 1110/0/0/0/0/0",
                  kif.row_out, kif.key_out, kif.key_held_out, kif.key_valid_out, kif.multi_out, kif.val_out);
      end
      exp_q.push_back(4'd3);
      for (int k = 1; k <= 3; k++) begin
         next_scan();
         n_cmp++;
         if (kif.key_valid_out !== (k == 3)) begin
            n_err++;
            $display("FAIL mid_post_valid scan %0d got %b required %b", k, kif.key_valid_out, (k == 3));
         end
      end
      n_cmp++;
      if (kif.key_out !== 4'd3) begin
         n_err++;
         $display("FAIL mid_key got %0d required 3", kif.key_out);
      end
      keys = 16'h0;
      repeat (4) next_scan();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL sb_leftover got %0d pending events required 0", exp_q.size());
      end
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      n_pulses = 0;
      exp_val  = 32'h0;
      keys     = 16'h0;
      rst      = 1'b1;
      test_reset();
      test_clean_press();
      test_bounce();
      test_multi();
      test_accum();
      test_reset_mid_debounce();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart to the multiplexed seven-segment display driver. It strobes the rows of a 4x4 passive matrix keypad one at a time with a one-cold, active-low pattern and samples the active-low column lines. It debounces over whole scans and emits one-cycle key events with a 4-bit key code. An optional 32-bit hex-digit accumulator formats entered digits so they can feed the display controller's 32-bit value input directly.

## Interface
Parameters:
- SCAN_COUNT, 100000: dwell per row is SCAN_COUNT+1 cycles; legal range is 3 or more.
- DEBOUNCE_SCANS, 4: number of consecutive identical full-scan results needed for a press or a release; legal range is 2 to 15.

Ports:
- clk_in  input  1  system clock; the only clock.
- rst_in  input  1  synchronous, active-high reset.
- col_in  input  4  keypad columns; asynchronous, pulled up, low means a key is closed on the driven row.
- row_out  output  4  row strobes; one-cold, active-low.
- key_out  output  4  code of the last accepted key: 4*row + col.
- key_valid_out  output  1  one-cycle pulse when a key press is accepted.
- key_held_out  output  1  high while an accepted key remains pressed.
- multi_out  output  1  high when the most recent full scan saw more than one closed key.
- val_out  output  32  hex-digit accumulator; see Configuration.

## Operation
- col_in passes through a 2-flop synchronizer and is inverted. Every use below refers to the synchronized, inverted value (1 = closed).
- Row sequencer:
  - Dwell counter runs 0..SCAN_COUNT.
  - When the counter equals SCAN_COUNT, the synchronized columns are sampled for the current row, the counter wraps to 0, and row_out rotates: 1110 → 1101 → 1011 → 0111 → 1110.
- Scan evaluation:
  - A per-scan closed-key count saturates at 2, and the last closed key's code is recorded.
  - scan_done is asserted for one cycle immediately after the row-3 sample.
  - Scan result is NONE (count 0), SINGLE(K) (count 1) or MULTI (count 2). The accumulators then clear for the next scan.
- Debounce FSM, updated only on scan_done:
  - IDLE:
    - SINGLE(K): load cand=K, match=1, go to CAND.
    - Otherwise: stay in IDLE.
  - CAND:
    - SINGLE(cand): match+1; when match reaches DEBOUNCE_SCANS, key_out<=cand, pulse key_valid_out, go to PRESSED.
    - SINGLE(other K): cand=K, match=1.
    - NONE or MULTI: go to IDLE.
  - PRESSED:
    - key_held_out=1.
    - NONE: rel+1; when rel reaches DEBOUNCE_SCANS, go to IDLE.
    - Any other result: rel=0.
    - No further key_valid_out is produced until the FSM returns to IDLE (no auto-repeat; rollover to a second key is ignored).
- multi_out is registered on every scan_done from that scan's result. It is independent of FSM state.
- Reset, including mid-scan or mid-debounce:
  - row_out=4'b1110; dwell counter, scan accumulators, match, rel and cand cleared; FSM in IDLE.
  - key_out=0, key_valid_out=0, key_held_out=0, multi_out=0, val_out=0.
  - No key event survives reset.

## Timing
- Column sample to key code: 2 synchronizer cycles plus sampling at the end of the dwell. Row settle time is SCAN_COUNT-1 cycles after the row change.
- Full scan period is 4*(SCAN_COUNT+1) cycles.
- key_valid_out, key_out, key_held_out, multi_out and val_out all update in the cycle after scan_done.
  - key_valid_out is high for exactly one cycle.
  - key_out holds its value until the next accepted key.
- Minimum press-to-event latency is DEBOUNCE_SCANS full scans.
- Minimum release latency is DEBOUNCE_SCANS scans of NONE.
- Widths:
  - Dwell counter is 32 bits wide.
  - match and rel are 4 bits wide and saturate at DEBOUNCE_SCANS.

## Configuration
- KEYPAD_ACCUM_EN defined:
  - On each key_valid_out, val_out <= {val_out[27:0], key_out_new}, shifting in one hex digit.
  - The oldest digit is discarded after 8 entries.
- KEYPAD_ACCUM_EN undefined:
  - The accumulator register is not built and val_out is tied to 32'h0.
  - All other behaviour is identical.

## Test plan
All scenarios use SCAN_COUNT=7 (32-cycle scans) and DEBOUNCE_SCANS=3.
- Reset: assert rst_in for 2 cycles with no keys pressed → row_out=4'b1110, every other output 0. After release, row_out steps to 4'b1101 after 8 cycles.
- Clean press: hold row 1/col 2 (col_in[2]=0 whenever row_out[1]=0) for 10 scans → exactly one key_valid_out pulse, key_out=6, pulse after the 3rd scan_done. key_held_out=1 until 3 NONE scans after release. val_out=32'h6 with KEYPAD_ACCUM_EN.
- Bounce: key 6 for 2 scans, then 1 NONE scan, repeated 4 times → no key_valid_out, key_held_out stays 0.
- Multi-key: keys 0 and 5 held together for 6 scans → multi_out=1 from the 1st scan_done, no key_valid_out. Releasing both gives multi_out=0 after the next scan.
- Accumulator wrap (KEYPAD_ACCUM_EN): cleanly enter keys 1,2,…,9 → val_out=32'h23456789. Same sequence without the macro → val_out=0 and 9 pulses.
- Reset mid-debounce: key 3 held 2 scans, then rst_in for 1 cycle while key 3 stays held → no pulse before the reset. Then a fresh debounce gives a pulse 3 scans after the reset, with key_out=3.
